// File: rtl/seven_segment_scanner_pkg.sv
// Shared seven-segment display definitions: scan FSM states, segment patterns
// and the BCD decode table used by every display block.
package seven_segment_scanner_pkg;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } scan_state_e;

   localparam int NIBBLE_W = 4;

   // Patterns are active-low, bit order g..a (seg[6]=g, seg[0]=a).
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   function automatic logic [6:0] bcd_seg(input logic [NIBBLE_W-1:0] nib);
      logic [6:0] pat;
      case (nib)
         4'd0:    pat = 7'b1000000;
         4'd1:    pat = 7'b1111001;
         4'd2:    pat = 7'b0100100;
         4'd3:    pat = 7'b0110000;
         4'd4:    pat = 7'b0011001;
         4'd5:    pat = 7'b0010010;
         4'd6:    pat = 7'b0000010;
         4'd7:    pat = 7'b1111000;
         4'd8:    pat = 7'b0000000;
         4'd9:    pat = 7'b0010000;
         default: pat = SEG_DASH;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/seven_segment_scanner_bcd_to_seg.sv
// Purely combinational BCD nibble to active-low seven-segment decoder.
module bcd_to_seg
   import seven_segment_scanner_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   assign seg_n = bcd_seg(nibble);

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment scanner: one digit per dwell period, with a
// short blank interval after every digit change to suppress ghosting.
module seven_segment_scanner
   import seven_segment_scanner_pkg::*;
#(
   parameter int NUMBER_OF_DIGITS         = 4,
   parameter int NUMBER_OF_BITS_PER_DIGIT = 4,
   parameter int CLK_HZ                   = 100_000_000,
   parameter int SCAN_HZ                  = 1000,
   parameter int BLANK_CYCLES             = 100
) (
   input  logic                                               clk,
   input  logic                                               rst,
   input  logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] number,
   input  logic [NUMBER_OF_DIGITS-1:0]                        digit_on,
   input  logic [NUMBER_OF_DIGITS-1:0]                        dp_on,
   output logic [NUMBER_OF_DIGITS-1:0]                        an,
   output logic [6:0]                                         seg,
   output logic                                               dp,
   output logic                                               scan_tick
);

   localparam int DIV   = CLK_HZ / SCAN_HZ;
   localparam int NB    = NUMBER_OF_BITS_PER_DIGIT;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IDX_W = (NUMBER_OF_DIGITS > 1) ? $clog2(NUMBER_OF_DIGITS) : 1;
   localparam int BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUMBER_OF_DIGITS - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_CYCLES - 1);

   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [IDX_W-1:0]            cur_idx_q, cur_idx_d;
   logic [IDX_W-1:0]            nxt_idx_q, nxt_idx_d;
   scan_state_e                 state_q, state_d;
   logic [BLK_W-1:0]            blk_q, blk_d;
   logic [NB-1:0]               nib_q, nib_d;
   logic                        on_q, on_d;
   logic                        dpo_q, dpo_d;
   logic [NUMBER_OF_DIGITS-1:0] an_q, an_d;
   logic [6:0]                  seg_q, seg_d;
   logic                        dp_q, dp_d;
   logic [3:0]                  dec_nib;
   logic [6:0]                  dec_seg;

   assign scan_tick = (cnt_q == CNT_LAST);
   assign an        = an_q;
   assign seg       = seg_q;
   assign dp        = dp_q;

   bcd_to_seg u_dec (
      .nibble (dec_nib),
      .seg_n  (dec_seg)
   );

   // nxt_idx_q names the digit that the coming tick will display, so the
   // first tick after reset shows digit 0.
   always_comb begin
      cnt_d     = scan_tick ? '0 : cnt_q + CNT_W'(1);
      cur_idx_d = cur_idx_q;
      nxt_idx_d = nxt_idx_q;
      state_d   = state_q;
      blk_d     = blk_q;
      nib_d     = nib_q;
      on_d      = on_q;
      dpo_d     = dpo_q;

      if (scan_tick) begin
         cur_idx_d = nxt_idx_q;
         nxt_idx_d = (nxt_idx_q == IDX_LAST) ? '0 : nxt_idx_q + IDX_W'(1);
         nib_d     = number[int'(nxt_idx_q)*NB +: NB];
         on_d      = digit_on[nxt_idx_q];
         dpo_d     = dp_on[nxt_idx_q];
         blk_d     = '0;
         state_d   = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
      end else if (state_q == ST_BLANK) begin
         if (BLANK_CYCLES == 0 || blk_q == BLK_LAST) begin
            state_d = ST_SHOW;
         end else begin
            blk_d = blk_q + BLK_W'(1);
         end
      end
   end

   // Output registers follow the next state so the blank interval starts on
   // the cycle right after the tick.
   always_comb begin
      dec_nib = 4'(nib_d);
      if (NB > 4 && |(nib_d >> 4)) begin
         dec_nib = 4'hF;
      end

      an_d  = '1;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
      if (state_d == ST_SHOW) begin
         if (on_d) begin
            an_d[cur_idx_d] = 1'b0;
         end
         seg_d = dec_seg;
         dp_d  = ~dpo_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         cur_idx_q <= '0;
         nxt_idx_q <= '0;
         state_q   <= ST_BLANK;
         blk_q     <= '0;
         nib_q     <= '0;
         on_q      <= 1'b0;
         dpo_q     <= 1'b0;
         an_q      <= '1;
         seg_q     <= SEG_BLANK;
         dp_q      <= 1'b1;
      end else begin
         cnt_q     <= cnt_d;
         cur_idx_q <= cur_idx_d;
         nxt_idx_q <= nxt_idx_d;
         state_q   <= state_d;
         blk_q     <= blk_d;
         nib_q     <= nib_d;
         on_q      <= on_d;
         dpo_q     <= dpo_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
      end
   end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner with a cycle-level reference
// model of the scan schedule (DIV=10, two blank cycles per digit).
module tb_seven_segment_scanner;

   localparam int ND     = 4;
   localparam int DIV    = 10;
   localparam int NBLANK = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] number = '0;
   logic [3:0]  digit_on = '0;
   logic [3:0]  dp_on = '0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        scan_tick;

   seven_segment_scanner #(
      .NUMBER_OF_DIGITS         (ND),
      .NUMBER_OF_BITS_PER_DIGIT (4),
      .CLK_HZ                   (100),
      .SCAN_HZ                  (10),
      .BLANK_CYCLES             (NBLANK)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .number    (number),
      .digit_on  (digit_on),
      .dp_on     (dp_on),
      .an        (an),
      .seg       (seg),
      .dp        (dp),
      .scan_tick (scan_tick)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: cycles since reset release, ticks seen, latched digit.
   int         c;
   int         n_ticks;
   int         lat_idx;
   logic [3:0] lat_nib;
   logic       lat_on;
   logic       lat_dp;

   function automatic logic [6:0] ref_seg(input logic [3:0] v);
      case (v)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, c);
      end
   endtask

   task automatic check_now();
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      if ((c % DIV) < NBLANK) begin
         e_an  = 4'hF;
         e_seg = 7'h7F;
         e_dp  = 1'b1;
      end else begin
         e_an  = lat_on ? ~(4'b0001 << lat_idx) : 4'hF;
         e_seg = ref_seg(lat_nib);
         e_dp  = ~lat_dp;
      end
      chk("scan_tick", {31'd0, scan_tick}, {31'd0, (c % DIV) == DIV - 1});
      chk("an", {28'd0, an}, {28'd0, e_an});
      chk("seg", {25'd0, seg}, {25'd0, e_seg});
      chk("dp", {31'd0, dp}, {31'd0, e_dp});
   endtask

   // Advance one clock; inputs present now are what a tick in this cycle captures.
   task automatic step();
      if ((c % DIV) == DIV - 1) begin
         lat_idx = n_ticks % ND;
         lat_nib = number[lat_idx*4 +: 4];
         lat_on  = digit_on[lat_idx];
         lat_dp  = dp_on[lat_idx];
         n_ticks++;
      end
      @(negedge clk);
      c++;
      check_now();
   endtask

   task automatic run(input int k);
      for (int i = 0; i < k; i++) step();
   endtask

   // Step until the first SHOW cycle of digit d, bounded.
   task automatic run_to_digit(input int d);
      int guard;
      guard = 0;
      do begin
         step();
         guard++;
      end while (!((c % DIV) == NBLANK && lat_idx == d && n_ticks > 0) && guard < 60);
      chk("run_to_digit_timeout", {31'd0, guard >= 60}, 32'd0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst     = 1'b0;
      c       = 0;
      n_ticks = 0;
      lat_idx = 0;
      lat_nib = '0;
      lat_on  = 1'b0;
      lat_dp  = 1'b0;
      #1 check_now();
   endtask

   logic [3:0] exp_an [5];
   int         k;
   int         nb;
   int         bad;
   logic [6:0] held_seg;

   initial begin
      exp_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
      c = 0;

      // Reset state
      #12;
      chk("reset_an", {28'd0, an}, 32'hF);
      chk("reset_seg", {25'd0, seg}, 32'h7F);
      chk("reset_dp", {31'd0, dp}, 32'd1);
      chk("reset_tick", {31'd0, scan_tick}, 32'd0);

      // Basic scan of 1234 with dp on digit 2
      number   = 16'h1234;
      digit_on = 4'hF;
      dp_on    = 4'b0100;
      release_reset();
      run(12);
      chk("d0_an", {28'd0, an}, {28'd0, exp_an[0]});
      chk("d0_seg", {25'd0, seg}, {25'd0, 7'b0011001});
      chk("d0_dp", {31'd0, dp}, 32'd1);
      for (int i = 1; i < 5; i++) begin
         run(DIV);
         chk("seq_an", {28'd0, an}, {28'd0, exp_an[i]});
         if (i == 2) chk("d2_dp", {31'd0, dp}, 32'd0);
      end

      // Tick period and blank length
      k = 0;
      while (!scan_tick && k < 20) begin
         step();
         k++;
      end
      chk("tick_found", {31'd0, scan_tick}, 32'd1);
      k = 0;
      do begin
         step();
         k++;
      end while (!scan_tick && k < 50);
      chk("tick_period", k, DIV);
      nb = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (an == 4'hF) nb++;
         else break;
      end
      chk("blank_len", nb, NBLANK);

      // Masked digit 1
      digit_on = 4'b1101;
      bad = 0;
      for (int i = 0; i < 45; i++) begin
         step();
         if (an == 4'b1101) bad++;
      end
      chk("an_never_1101", bad, 0);
      run_to_digit(1);
      chk("d1_masked_an", {28'd0, an}, 32'hF);

      // Dash for nibbles above 9
      number   = 16'hFA00;
      digit_on = 4'hF;
      dp_on    = 4'h0;
      run_to_digit(0);
      run_to_digit(2);
      chk("d2_dash", {25'd0, seg}, {25'd0, 7'b0111111});
      run_to_digit(3);
      chk("d3_dash", {25'd0, seg}, {25'd0, 7'b0111111});
      run_to_digit(0);
      chk("d0_zero", {25'd0, seg}, {25'd0, 7'b1000000});
      run_to_digit(1);
      chk("d1_zero", {25'd0, seg}, {25'd0, 7'b1000000});

      // Mid-dwell change must not disturb the shown digit
      number = 16'h0008;
      run_to_digit(0);
      chk("d0_eight", {25'd0, seg}, {25'd0, 7'b0000000});
      run(2);
      number = 16'h0001;
      run(3);
      held_seg = seg;
      chk("mid_dwell_hold", {25'd0, held_seg}, {25'd0, 7'b0000000});
      run_to_digit(1);
      run_to_digit(0);
      chk("d0_new_value", {25'd0, seg}, {25'd0, 7'b1111001});

      // Asynchronous reset during SHOW
      number = 16'h1234;
      run_to_digit(2);
      run(2);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_an", {28'd0, an}, 32'hF);
      chk("async_rst_seg", {25'd0, seg}, 32'h7F);
      chk("async_rst_dp", {31'd0, dp}, 32'd1);
      repeat (2) @(posedge clk);
      release_reset();
      k = 0;
      while (an == 4'hF && k < 40) begin
         step();
         k++;
      end
      chk("first_after_reset_an", {28'd0, an}, 32'hE);
      chk("first_after_reset_seg", {25'd0, seg}, {25'd0, 7'b0011001});

      // Randomized inputs against the model
      for (int i = 0; i < 30; i++) begin
         number   = 16'($urandom);
         digit_on = 4'($urandom);
         dp_on    = 4'($urandom);
         run(int'($urandom_range(1, 25)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seven_segment_scanner.md
SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 SHALL have parameter NUMBER_OF_DIGITS, default 4, number of multiplexed digits.
REQ-002 SHALL have parameter NUMBER_OF_BITS_PER_DIGIT, default 4, BCD nibble width.
REQ-003 SHALL have parameter CLK_HZ, default 100_000_000, input clock frequency.
REQ-004 SHALL have parameter SCAN_HZ, default 1000, per-digit dwell rate; DIV = CLK_HZ/SCAN_HZ.
REQ-005 SHALL have parameter BLANK_CYCLES, default 100, anti-ghosting blank interval in clk cycles; must be less than DIV.
REQ-006 SHALL have port clk  input  1  clock.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port number  input  NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT  packed BCD, digit 0 in bits [3:0] (seconds units) up to digit 3 in [15:12].
REQ-009 SHALL have port digit_on  input  NUMBER_OF_DIGITS  per-digit visibility, 1 = show; blink masks come in here.
REQ-010 SHALL have port dp_on  input  NUMBER_OF_DIGITS  per-digit decimal point request, 1 = lit.
REQ-011 SHALL have port an  output  NUMBER_OF_DIGITS  anode enables, active-low.
REQ-012 SHALL have port seg  output  7  cathodes, active-low, seg[0]=a .. seg[6]=g.
REQ-013 SHALL have port dp  output  1  decimal point cathode, active-low.
REQ-014 SHALL have port scan_tick  output  1  one-cycle pulse at each digit advance.

Function
REQ-015 Prescaler SHALL count 0..DIV-1 and wrap; scan_tick SHALL be high for exactly the cycle in which the count equals DIV-1.
REQ-016 Digit index SHALL advance 0,1,..,NUMBER_OF_DIGITS-1,0 on each scan_tick.
REQ-017 FSM states SHALL be BLANK and SHOW; scan_tick SHALL force BLANK from either state; BLANK SHALL move to SHOW after BLANK_CYCLES cycles.
REQ-018 In BLANK, an SHALL be all ones, and seg and dp SHALL be all ones.
REQ-019 On scan_tick, the nibble and the digit_on and dp_on bits of the new index SHALL be latched; later input changes SHALL NOT affect the digit until the next tick.
REQ-020 In SHOW, an SHALL drive low only the bit of the current index, and only if its latched digit_on is 1; otherwise an SHALL stay all ones.
REQ-021 seg SHALL decode latched nibbles 0-9 to the standard patterns: 0=1000000, 1=1111001, 4=0011001, 8=0000000 (bits g..a).
REQ-022 Nibbles 10-15 SHALL display a dash: seg=0111111 (only g lit).
REQ-023 dp SHALL be 0 in SHOW when the latched dp_on bit is 1, otherwise 1.
REQ-024 an, seg and dp SHALL be registered outputs, with no combinational path from any input to any output.
REQ-025 Latency SHALL be BLANK_CYCLES+1 clk from scan_tick to the first SHOW cycle of the new digit.

Reset
REQ-026 Reset SHALL force: prescaler 0, index 0, state BLANK, blank counter 0, an all ones, seg all ones, dp 1, scan_tick 0, latched data 0.
REQ-027 Reset asserted mid-SHOW SHALL blank all outputs in the same cycle (asynchronous).
REQ-028 After reset release, digit 0 SHALL appear first, following the first scan_tick.

Structure
REQ-029 The BCD-to-segment table, the dash pattern and the all-ones blank pattern SHALL live in a shared display package, reused by other display blocks.
REQ-030 The decode SHALL be one sub-module, bcd_to_seg (nibble in, 7-bit active-low out, purely combinational); the FSM and counters SHALL stay in seven_segment_scanner.

Verification
Parameters for all scenarios: CLK_HZ=100, SCAN_HZ=10 (DIV=10), BLANK_CYCLES=2.
REQ-031 Reset, then number=16'h1234, digit_on=4'hF, dp_on=4'b0100 -> digit 0: an=1110, seg=0011001; digit 2: an=1011, dp=0; index sequence 0,1,2,3,0.
REQ-032 Count cycles between scan_tick pulses -> exactly 10; an=1111 for exactly 2 cycles after each tick.
REQ-033 digit_on=4'b1101 -> an never equals 1101; digit 1 slot stays 1111 for its whole dwell.
REQ-034 number=16'hFA00 -> digits 2 and 3 show seg=0111111; digits 0 and 1 show seg=1000000.
REQ-035 Change number in mid-dwell of digit 0 -> seg unchanged until the next visit to digit 0.
REQ-036 Assert rst during SHOW -> an=1111, seg=1111111, dp=1 in the same cycle; after release, digit 0 is shown first.
